rotate_shift_engine: RTL and testbench

//   Parametrised multi-cycle rotator/shifter register, the successor to the fixed 100-bit

---
 rtl/rotate_shift_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_rotate_shift_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_shift_engine.sv
// rotate_shift_engine
//   Multi-cycle rotator/shifter register. Holds a WIDTH-bit word that can be
//   parallel-loaded, single-stepped by one position (legacy ena rotator), or
//   moved by a variable amount under a start/busy/done command handshake,
//   at up to STEP positions per clock.
//
//   Optional feature macro: ROT_CARRY_EN (adds the carry output and its logic).
//
// Ports
//   clk       rising-edge clock
//   areset_n  asynchronous reset, active-low
//   load      q <= data; highest priority, aborts a running command
//   data      parallel load value
//   ena       IDLE single step: 01 rotate right 1, 10 rotate left 1, else hold
//   start     begin a command (sampled in IDLE only)
//   mode      0 ROR, 1 ROL, 2 SRL, 3 SLL, 4 SRA, 5-7 illegal
//   amt       positions to move, clamped to WIDTH
//   q         register contents
//   busy      high while a command is running
//   done      one-cycle pulse with the final q update of a command
//   err       one-cycle pulse on start with an illegal mode
//   carry     (ROT_CARRY_EN only) last bit moved out of q by the latest step

module rotate_shift_engine #(
    parameter int WIDTH = 100,
    parameter int STEP  = 4,
    parameter int AMT_W = 7
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       ena,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef ROT_CARRY_EN
    ,
    output logic             carry
`endif
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    typedef enum logic [2:0] {
        M_ROR = 3'd0,
        M_ROL = 3'd1,
        M_SRL = 3'd2,
        M_SLL = 3'd3,
        M_SRA = 3'd4
    } mode_e;

    localparam logic [AMT_W-1:0] AMT_MAX  = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    state_e           state, state_n;
    mode_e            mode_r, mode_n;
    logic [AMT_W-1:0] rem, rem_n;
    logic [WIDTH-1:0] q_n;
    logic             done_n, err_n;

    logic [AMT_W-1:0] amt_c;
    logic [AMT_W-1:0] k_start, k_run;
    logic [AMT_W-1:0] rem_start_left, rem_run_left;
    logic             mode_legal;

`ifdef ROT_CARRY_EN
    logic carry_n;
`endif

    // Move v by k positions (k <= WIDTH). Shifts by WIDTH yield 0 / all-sign,
    // rotates by 0 or WIDTH yield v.
    function automatic logic [WIDTH-1:0] step_q(input logic [WIDTH-1:0] v,
                                                input mode_e m,
                                                input logic [AMT_W-1:0] k);
        logic [WIDTH-1:0] r;
        case (m)
            M_ROR:   r = (v >> k) | (v << (WIDTH - int'(k)));
            M_ROL:   r = (v << k) | (v >> (WIDTH - int'(k)));
            M_SRL:   r = v >> k;
            M_SLL:   r = v << k;
            M_SRA:   r = $signed(v) >>> k;
            default: r = v;
        endcase
        return r;
    endfunction

`ifdef ROT_CARRY_EN
    // Bits leave one at a time, so the last one out of a k-position step is
    // v[k-1] when moving right and v[WIDTH-k] when moving left. k >= 1.
    function automatic logic out_bit(input logic [WIDTH-1:0] v,
                                     input mode_e m,
                                     input logic [AMT_W-1:0] k);
        logic [WIDTH-1:0] t;
        if (m == M_ROL || m == M_SLL) begin
            t = v >> (WIDTH - int'(k));
        end else begin
            t = v >> (k - AMT_W'(1));
        end
        return t[0];
    endfunction
`endif

    assign busy = (state == S_RUN);

    always_comb begin
        amt_c          = (amt > AMT_MAX) ? AMT_MAX : amt;
        k_start        = (amt_c < STEP_AMT) ? amt_c : STEP_AMT;
        k_run          = (rem < STEP_AMT) ? rem : STEP_AMT;
        rem_start_left = amt_c - k_start;
        rem_run_left   = rem - k_run;
        mode_legal     = (mode <= 3'd4);
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_r;
        rem_n   = rem;
        q_n     = q;
        done_n  = 1'b0;
        err_n   = 1'b0;
`ifdef ROT_CARRY_EN
        carry_n = carry;
`endif
        case (state)
            S_IDLE: begin
                if (load) begin
                    q_n = data;
`ifdef ROT_CARRY_EN
                    carry_n = 1'b0;
`endif
                end else if (start) begin
                    if (!mode_legal) begin
                        err_n = 1'b1;
                    end else begin
                        mode_n = mode_e'(mode);
                        if (amt_c == '0) begin
                            done_n = 1'b1;
                        end else begin
                            // First step is taken on the start edge itself.
                            q_n   = step_q(q, mode_e'(mode), k_start);
                            rem_n = rem_start_left;
`ifdef ROT_CARRY_EN
                            carry_n = out_bit(q, mode_e'(mode), k_start);
`endif
                            if (rem_start_left == '0) begin
                                done_n = 1'b1;
                            end else begin
                                state_n = S_RUN;
                            end
                        end
                    end
                end else if (ena == 2'b01) begin
                    q_n = {q[0], q[WIDTH-1:1]};
`ifdef ROT_CARRY_EN
                    carry_n = q[0];
`endif
                end else if (ena == 2'b10) begin
                    q_n = {q[WIDTH-2:0], q[WIDTH-1]};
`ifdef ROT_CARRY_EN
                    carry_n = q[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                if (load) begin
                    q_n     = data;
                    rem_n   = '0;
                    state_n = S_IDLE;
`ifdef ROT_CARRY_EN
                    carry_n = 1'b0;
`endif
                end else begin
                    q_n   = step_q(q, mode_r, k_run);
                    rem_n = rem_run_left;
`ifdef ROT_CARRY_EN
                    carry_n = out_bit(q, mode_r, k_run);
`endif
                    if (rem_run_left == '0) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state  <= S_IDLE;
            mode_r <= M_ROR;
            rem    <= '0;
            q      <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
`ifdef ROT_CARRY_EN
            carry  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            mode_r <= mode_n;
            rem    <= rem_n;
            q      <= q_n;
            done   <= done_n;
            err    <= err_n;
`ifdef ROT_CARRY_EN
            carry  <= carry_n;
`endif
        end
    end

endmodule

// File: tb/tb_rotate_shift_engine.sv
module tb_rotate_shift_engine;

    localparam int W = 100;

    logic          clk;
    logic          areset_n;
    logic          load;
    logic [W-1:0]  data;
    logic [1:0]    ena;
    logic          start;
    logic [2:0]    mode;
    logic [6:0]    amt;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;
    logic          err;
`ifdef ROT_CARRY_EN
    logic          carry;
`endif

    rotate_shift_engine #(.WIDTH(W), .STEP(4), .AMT_W(7)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .load     (load),
        .data     (data),
        .ena      (ena),
        .start    (start),
        .mode     (mode),
        .amt      (amt),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .err      (err)
`ifdef ROT_CARRY_EN
        ,
        .carry    (carry)
`endif
    );

    typedef struct {
        bit           is_err;
        logic [W-1:0] q;
        logic         c;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every done/err pulse consumes one expected response.
    always @(negedge clk) begin
        if (areset_n && (done || err)) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b q=%h, none expected", done, err, q);
            end else begin
                exp_t e;
                logic ok;
                e  = sb.pop_front();
                ok = (err === e.is_err) && (done === !e.is_err) && (q === e.q);
`ifdef ROT_CARRY_EN
                ok = ok && (carry === e.c);
`endif
                if (!ok) begin
                    n_fail++;
                    $display("FAIL sb_%s: got done=%0b err=%0b q=%h, expected err=%0b q=%h",
                             e.name, done, err, q, e.is_err, e.q);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        data = v;
        tick();
        load = 1'b0;
    endtask

    task automatic push(input string name, input bit is_err, input logic [W-1:0] v, input logic c);
        exp_t e;
        e.name   = name;
        e.is_err = is_err;
        e.q      = v;
        e.c      = c;
        sb.push_back(e);
    endtask

    // Issue a legal command and check start-to-done latency and busy cycles.
    task automatic run_cmd(input string name, input logic [2:0] m, input logic [6:0] a,
                           input logic [W-1:0] expq, input logic expc, input int lat);
        int e;
        int nb;
        push(name, 1'b0, expq, expc);
        start = 1'b1;
        mode  = m;
        amt   = a;
        tick();
        start = 1'b0;
        e  = 1;
        nb = 0;
        while (!done && e < 60) begin
            if (busy) nb++;
            tick();
            e++;
        end
        chk({name, "_latency"}, W'(e), W'(lat));
        chk({name, "_busy_cycles"}, W'(nb), W'(lat - 1));
        chk({name, "_busy_after_done"}, W'(busy), '0);
    endtask

    logic [W-1:0] one;
    logic [W-1:0] msb;

    initial begin
        one      = 1;
        msb      = one << (W - 1);
        areset_n = 1'b0;
        load     = 1'b0;
        data     = '0;
        ena      = 2'b00;
        start    = 1'b0;
        mode     = 3'd0;
        amt      = '0;

        #2;
        chk("reset_q", q, '0);
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        chk("reset_err", W'(err), '0);
        #10 areset_n = 1'b1;
        tick();

        // 1: ROR 10 on 1, steps 4,4,2
        do_load(one);
        run_cmd("ror10", 3'd0, 7'd10, one << 90, 1'b0, 3);
        chk("ror10_q", q, one << 90);

        // 2: SRA clamped to 100 on MSB only
        do_load(msb);
        run_cmd("sra127", 3'd4, 7'd127, '1, 1'b1, 25);

        // Further directed commands
        do_load(W'(100'hF0));
        run_cmd("srl4", 3'd2, 7'd4, W'(100'hF), 1'b0, 1);
        do_load(one);
        run_cmd("sll99", 3'd3, 7'd99, msb, 1'b0, 25);
        do_load(one);
        run_cmd("sll100", 3'd3, 7'd100, '0, 1'b1, 25);
        do_load(msb);
        run_cmd("rol1", 3'd1, 7'd1, one, 1'b1, 1);
        do_load(W'(100'h5));
        run_cmd("ror100", 3'd0, 7'd100, W'(100'h5), 1'b0, 25);
        do_load(msb);
        run_cmd("sra3", 3'd4, 7'd3, W'(100'hF) << 96, 1'b0, 1);

        // 3: load aborts a running SLL 40, no done
        do_load(one);
        start = 1'b1;
        mode  = 3'd3;
        amt   = 7'd40;
        tick();
        start = 1'b0;
        chk("abort_busy_running", W'(busy), W'(1));
        repeat (3) tick();
        load = 1'b1;
        data = W'(100'hABC);
        tick();
        load = 1'b0;
        chk("abort_busy", W'(busy), '0);
        chk("abort_q", q, W'(100'hABC));
        repeat (15) tick();
        chk("abort_q_held", q, W'(100'hABC));

        // 4: zero amount and illegal mode
        run_cmd("amt0", 3'd1, 7'd0, W'(100'hABC), 1'b0, 1);
        push("illegal", 1'b1, W'(100'hABC), 1'b0);
        start = 1'b1;
        mode  = 3'd6;
        amt   = 7'd5;
        tick();
        start = 1'b0;
        chk("illegal_err", W'(err), W'(1));
        chk("illegal_busy", W'(busy), '0);
        tick();
        chk("illegal_err_clear", W'(err), '0);
        chk("illegal_q", q, W'(100'hABC));

        // 5: legacy ena stepping, then load beats start
        do_load(W'(100'h3));
        ena = 2'b01;
        tick();
        chk("ena_ror1", q, msb | one);
`ifdef ROT_CARRY_EN
        chk("ena_ror1_carry", W'(carry), W'(1));
`endif
        ena = 2'b10;
        tick();
        chk("ena_rol1", q, W'(100'h3));
        ena = 2'b11;
        tick();
        chk("ena_hold11", q, W'(100'h3));
        ena = 2'b00;
        tick();
        chk("ena_hold00", q, W'(100'h3));
        load  = 1'b1;
        data  = W'(100'h55);
        start = 1'b1;
        mode  = 3'd0;
        amt   = 7'd5;
        tick();
        load  = 1'b0;
        start = 1'b0;
        chk("load_wins_q", q, W'(100'h55));
        chk("load_wins_busy", W'(busy), '0);
        tick();

        // 6: async reset mid-run
        do_load(W'(100'h123));
        start = 1'b1;
        mode  = 3'd1;
        amt   = 7'd99;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 areset_n = 1'b0;
        #1;
        chk("rst_mid_q", q, '0);
        chk("rst_mid_busy", W'(busy), '0);
        chk("rst_mid_done", W'(done), '0);
        repeat (2) tick();
        #2 areset_n = 1'b1;
        repeat (30) tick();
        chk("rst_after_q", q, '0);

        chk("scoreboard_empty", W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
